// File: rtl/aes_pkg.sv
// Shared AES datapath types and byte/permutation helpers used by the round
// stages. Byte k of a state lives at [127-8k -: 8], i.e. row k%4 of column k/4.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  localparam int NB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } ssr_state_e;

  function automatic logic [7:0] get_byte(state_t s, int idx);
    return s[127-8*idx -: 8];
  endfunction

  function automatic state_t set_byte(state_t s, int idx, logic [7:0] b);
    state_t r;
    r = s;
    r[127-8*idx -: 8] = b;
    return r;
  endfunction

  // Output row r, column c takes the byte from row r, column (c+r) mod 4.
  function automatic state_t shift_rows(state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < NB; c++) begin
      for (int row = 0; row < NB; row++) begin
        r = set_byte(r, NB*c + row, get_byte(s, NB*((c + row) % NB) + row));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sub_shift_rows_if.sv
// Valid/ready bundle between the round controller, sub_shift_rows and the
// downstream mix_column stage.
interface sub_shift_rows_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/sbox.sv
// Combinational AES forward S-box (FIPS-197 table), byte in / byte out.
module sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Entry 0 sits in the top byte so entry n is found at slice (255-n) = ~n.
  localparam logic [2047:0] SBOX_TABLE = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byte_o = SBOX_TABLE[{~byte_i, 3'b000} +: 8];

endmodule

// File: rtl/sub_shift_rows.sv
// Sequential SubBytes + ShiftRows: SBOXES bytes are substituted in place per
// cycle, and the ShiftRows view of the working register is the output.
module sub_shift_rows import aes_pkg::*; #(
  parameter int SBOXES = 4
) (
  input logic             clk,
  input logic             rst_n,
  sub_shift_rows_if.slave bus
);

  localparam int STEPS = 16 / SBOXES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (SBOXES != 4 && SBOXES != 8 && SBOXES != 16) begin : g_bad_sboxes
    $error("sub_shift_rows: SBOXES must be 4, 8 or 16");
  end

  ssr_state_e    state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  state_t        work_q, work_d;
  state_t        sub_work_s;
  logic          in_ready_s;
  int            base_s;
  logic [7:0]    sb_in_s  [SBOXES];
  logic [7:0]    sb_out_s [SBOXES];

  assign base_s = int'(step_q) * SBOXES;

  for (genvar g = 0; g < SBOXES; g++) begin : g_sbox
    assign sb_in_s[g] = get_byte(work_q, base_s + g);
    sbox u_sbox (
      .byte_i (sb_in_s[g]),
      .byte_o (sb_out_s[g])
    );
  end

  // Working register with this step's substituted bytes written back in place.
  always_comb begin
    sub_work_s = work_q;
    for (int g = 0; g < SBOXES; g++) begin
      sub_work_s = set_byte(sub_work_s, base_s + g, sb_out_s[g]);
    end
  end

  assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);

  // Next-state logic; a new capture may coincide with the output handshake in DONE.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_state;
          step_d  = '0;
          state_d = SUB;
        end else begin
          state_d = IDLE;
        end
      end
      SUB: begin
        work_d = sub_work_s;
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready && bus.in_valid) begin
          work_d  = bus.in_state;
          step_d  = '0;
          state_d = SUB;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        work_d  = '0;
      end
    endcase
  end

  // State, step counter and working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      work_q  <= work_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = shift_rows(work_q);

endmodule

// File: doc/sub_shift_rows.md
# sub_shift_rows

Sequential SubBytes + ShiftRows stage of the AES round datapath, sitting directly upstream of `mix_column`. It accepts a 128-bit state over a valid/ready handshake and substitutes bytes through a configurable number of shared S-box instances over several cycles. It presents the ShiftRows-permuted result, column by column, in the 32-bit column layout `mix_column` consumes. Holding the result under backpressure lets the round controller stall the pipeline freely.

## Interface
- `SBOXES`, default 4: S-box instances, which is bytes substituted per cycle. Legal values are 4, 8 and 16. Any other value is a elaboration error.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: `in_state` is valid.
- `in_ready`  out  1: block can accept a state this cycle.
- `in_state`  in  128: input state, column-major.
  - Byte k = `in_state[127-8k -: 8]`.
  - Byte k holds row k%4 of column k/4.
- `out_valid`  out  1: `out_state` holds a finished result.
- `out_ready`  in  1: downstream accepts the result.
- `out_state`  out  128: ShiftRows(SubBytes(input)), same byte layout as `in_state`. Column c occupies `out_state[127-32c -: 32]`, with row 0 in the MSB byte, matching `mix_column` b0..b3.

## Operation
- FSM states: IDLE, SUB, DONE.
  - IDLE → SUB when `in_valid && in_ready`. Capture `in_state` into the working register and clear the step counter.
  - SUB: each cycle, substitute `SBOXES` bytes at byte indices step·SBOXES .. step·SBOXES+SBOXES-1 and write them back in place. The step counter increments.
  - SUB → DONE after the last step, when step == 16/SBOXES−1. The counter is `$clog2(16/SBOXES)` bits wide, with a minimum of 1 bit. It never wraps within a block.
  - DONE: `out_valid`=1. On `out_valid && out_ready` the block leaves DONE. It goes to SUB if a new input handshakes in the same cycle, otherwise to IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). This is combinational.
- ShiftRows is pure wiring on the working register. Output row r, column c = substituted byte at row r, column (c+r) mod 4.
- `out_state` is driven from the register, so it is stable for the whole DONE period regardless of `out_ready`.
- Changes on `in_state` after capture have no effect.
- Outside DONE, `out_state` is don't-care for consumers but must be deterministic: it is the shifted register contents.

## Timing
- Reset values:
  - state = IDLE.
  - Working register = 0, so `out_state` = 0.
  - Step counter = 0.
  - `out_valid` = 0.
  - `in_ready` = 1.
- Latency: input handshake at edge T → `out_valid` high after edge T+16/SBOXES. That is 4 cycles at the default.
- Sustained throughput: one block per 16/SBOXES+1 cycles with `out_ready` held high. Output and input handshakes coincide in DONE.
- Backpressure: with `out_ready`=0, DONE holds indefinitely. `in_ready` stays 0 and the block accepts no new input.
- `rst_n` asserted mid-SUB or mid-DONE: immediately return to reset values. The partial block is discarded and no `out_valid` pulse is produced.
- Reset deassertion must be synchronized externally. The block requires no recovery cycle beyond that.

## Structure
- Shared package `aes_pkg` holds:
  - `state_t` (logic [127:0]) and `word_t` (logic [31:0]).
  - `NB`=4.
  - Helper functions `get_byte`/`set_byte` (state, index).
  - The ShiftRows permutation as a function `shift_rows(state_t)`. Later the inverse and encryption-round blocks reuse it.
- Sub-module `sbox`: combinational byte in / byte out, 256-entry FIPS-197 table. It is instantiated `SBOXES` times in a generate loop and is also the unit-test target for the table.

## Test plan
- Reset: hold `rst_n`=0, then release.
  - Required: `out_valid`=0, `in_ready`=1, `out_state`=0.
- FIPS-197 App. B round 1: input 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: after 4 cycles, `out_state` = d4bf5d30e0b452aeb84111f11e2798e5.
  - Feed column 0 into `mix_column`: required result 046681e5.
- Uniform inputs:
  - Input all-zero → required output all 63.
  - Input all-01 → required output all 7c.
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 10 cycles: `out_state` stable, `in_ready`=0.
  - Then raise `out_ready` with a second input valid: both handshakes occur in the same cycle.
  - Second result appears 4 cycles later.
- Reset mid-SUB: assert `rst_n` two cycles after the input handshake.
  - Required: no `out_valid` ever for that block.
  - The next input after release produces the correct result.
- Parameter sweep: rerun the FIPS vector at SBOXES=8 and SBOXES=16.
  - Required: identical `out_state`, with latency 2 and 1 cycles respectively.
